reg_select_encoder: RTL and testbench



---
 rtl/reg_select_encoder.sv | 101 ++++++++++
 tb/tb_reg_select_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_select_encoder.sv
// Sequential 4-to-2 register-select encoder: captures a multi-hot select vector,
// then emits the index of each set bit, lowest first, one per output handshake.
module reg_select_encoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] register,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] regNo,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       last,
    output logic [2:0] count,
    output logic       empty_err
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] pending_reg, pending_next;
    logic [2:0] count_reg, count_next;
    logic       empty_err_reg, empty_err_next;

    logic [3:0] below;
    logic [3:0] lowest;
    logic [2:0] popcount;

    // below[i] is set when any lower pending bit exists, isolating the lowest one
    assign below[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_low
            assign lowest[gi] = pending_reg[gi] & ~below[gi];
            if (gi < 3) begin : g_chain
                assign below[gi+1] = below[gi] | pending_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        popcount = 3'd0;
        for (int i = 0; i < 4; i++) begin
            popcount = popcount + {2'b00, register[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pending_reg   <= 4'b0000;
            count_reg     <= 3'd0;
            empty_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            count_reg     <= count_next;
            empty_err_reg <= empty_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg;
        count_next     = count_reg;
        empty_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    count_next = popcount;
                    if (register != 4'b0000) begin
                        pending_next = register;
                        state_next   = EMIT;
                    end else begin
                        empty_err_next = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pending_next = pending_reg & ~lowest;
                    if (pending_reg == lowest) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from registers only; regNo/last are forced low when idle
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == EMIT);
    assign regNo     = out_valid ? {lowest[3] | lowest[2], lowest[3] | lowest[1]} : 2'b00;
    assign last      = out_valid && (pending_reg == lowest);
    assign count     = count_reg;
    assign empty_err = empty_err_reg;

endmodule

// File: tb/tb_reg_select_encoder.sv
// Testbench for reg_select_encoder: directed scenarios plus random traffic,
// checked against a queue-based model of the emitted register numbers.
module tb_reg_select_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] register = 4'b0000;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] regNo;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       last;
    logic [2:0] count;
    logic       empty_err;

    int vectors = 0;
    int fails   = 0;

    // Model: queue of register numbers still to be emitted, plus count/error state
    logic [1:0] q[$];
    logic [2:0] m_count = 3'd0;
    logic       m_err = 1'b0;

    logic [8:0] obs;
    assign obs = {in_ready, out_valid, regNo, last, count, empty_err};

    localparam logic [8:0] RESET_OBS = 9'b1_0_00_0_000_0;

    reg_select_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .register  (register),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .regNo     (regNo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .last      (last),
        .count     (count),
        .empty_err (empty_err)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] exp_out();
        logic       v;
        logic [1:0] r;
        logic       l;
        v = (q.size() > 0);
        r = v ? q[0] : 2'b00;
        l = (q.size() == 1);
        return {~v, v, r, l, m_count, m_err};
    endfunction

    task automatic model_reset();
        q.delete();
        m_count = 3'd0;
        m_err   = 1'b0;
    endtask

    // Apply inputs for the coming edge and advance the model past that edge
    task automatic drive(input logic [3:0] vec, input logic iv, input logic ordy);
        register  = vec;
        in_valid  = iv;
        out_ready = ordy;
        if (q.size() == 0) begin
            m_err = iv && (vec == 4'b0000);
            if (iv) begin
                m_count = 3'($countones(vec));
                for (int i = 0; i < 4; i++) begin
                    if (vec[i]) q.push_back(2'(i));
                end
                $display("capture vec=%b count=%0d", vec, m_count);
            end
        end else begin
            m_err = 1'b0;
            if (ordy) begin
                $display("xfer regNo=%0d last=%0d", q[0], q.size() == 1);
                void'(q.pop_front());
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        vectors++;
        if (obs !== RESET_OBS) begin
            fails++;
            $display("FAIL reset_hold got=%b exp=%b", obs, RESET_OBS);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== RESET_OBS) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", c, obs, RESET_OBS);
            end
            drive(4'b0000, 1'b0, 1'b0);
        end
    endtask

    task automatic test_basic();
        logic [1:0] seen[$];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL basic_1011 cyc=%0d got=%b exp=%b", c, obs, exp_out());
            end
            if (out_valid) seen.push_back(regNo);
            drive(4'b1011, c == 0, 1'b1);
        end
        vectors++;
        if (seen.size() != 3 || seen[0] !== 2'd0 || seen[1] !== 2'd1 || seen[2] !== 2'd3) begin
            fails++;
            $display("FAIL basic_order got=%p exp='{0,1,3}", seen);
        end
    endtask

    task automatic test_stall();
        int held = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL stall_1000 cyc=%0d got=%b exp=%b", c, obs, exp_out());
            end
            if (out_valid && regNo == 2'd3 && last) held++;
            drive(4'b1000, c == 0, c >= 4);
        end
        vectors++;
        if (held != 4) begin
            fails++;
            $display("FAIL stall_held got=%0d exp=4", held);
        end
    endtask

    task automatic test_zero();
        int pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL zero_vec cyc=%0d got=%b exp=%b", c, obs, exp_out());
            end
            if (empty_err) pulses++;
            if (c == 0) drive(4'b0000, 1'b1, 1'b1);
            else        drive(4'b0110, c == 1, 1'b1);
        end
        vectors++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL zero_pulse got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seen[$];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", c, obs, exp_out());
            end
            if (out_valid) seen.push_back(regNo);
            drive((c == 0) ? 4'b1111 : 4'b0101, c <= 5, 1'b1);
        end
        vectors++;
        if (seen.size() != 6 || seen[0] !== 2'd0 || seen[1] !== 2'd1 || seen[2] !== 2'd2 ||
            seen[3] !== 2'd3 || seen[4] !== 2'd0 || seen[5] !== 2'd2) begin
            fails++;
            $display("FAIL b2b_order got=%p exp='{0,1,2,3,0,2}", seen);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL midrst_pre cyc=%0d got=%b exp=%b", c, obs, exp_out());
            end
            drive(4'b1110, c == 0, 1'b1);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        drive(4'b0000, 1'b0, 1'b1);
        #1;
        vectors++;
        if (obs !== RESET_OBS) begin
            fails++;
            $display("FAIL midrst_async got=%b exp=%b", obs, RESET_OBS);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL midrst_post cyc=%0d got=%b exp=%b", c, obs, exp_out());
            end
            drive(4'b0000, 1'b0, 1'b1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_out()) begin
                fails++;
                $display("FAIL random cyc=%0d got=%b exp=%b", c, obs, exp_out());
            end
            drive(4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
